// File: rtl/int8_to_int16_expand.sv
// INT8 -> INT16 dequantization front-end: sign-extends packed INT8 lanes, applies a
// clamped left shift, and re-serializes each input word into BEATS narrower output beats.
module int8_to_int16_expand #(
    parameter int IN_LANES  = 4,
    parameter int OUT_LANES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [8*IN_LANES-1:0]    in_data,
    input  logic [3:0]               in_shift,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [16*OUT_LANES-1:0]  out_data,
    output logic                     out_last
);

    localparam int BEATS = IN_LANES / OUT_LANES;
    localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [8*IN_LANES-1:0]   hold_q;
    logic [3:0]              shift_q;
    logic                    load;
    logic                    out_fire;
    logic                    last_beat;
    logic [7:0]              lane_byte;
    logic [15:0]             lane_ext;

    assign last_beat = (idx_q == IDX_W'(BEATS - 1));
    assign out_valid = (state_q == S_FULL);
    assign out_last  = out_valid && last_beat;
    assign out_fire  = out_valid && out_ready;
    // Ready early on the final beat so consecutive words stream without a bubble.
    assign in_ready  = (state_q == S_EMPTY) || (out_fire && last_beat);
    assign load      = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (out_fire) begin
            if (!last_beat) begin
                idx_d = idx_q + 1'b1;
            end else begin
                state_d = S_EMPTY;
            end
        end
        if (load) begin
            state_d = S_FULL;
            idx_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Shift is clamped to 8 at capture so the datapath never sees 9..15.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q  <= '0;
            shift_q <= '0;
        end else if (load) begin
            hold_q  <= in_data;
            shift_q <= (in_shift > 4'd8) ? 4'd8 : in_shift;
        end
    end

    always_comb begin
        out_data  = '0;
        lane_byte = '0;
        lane_ext  = '0;
        for (int j = 0; j < OUT_LANES; j++) begin
            lane_byte = hold_q[(int'(idx_q) * OUT_LANES + j) * 8 +: 8];
            lane_ext  = {{8{lane_byte[7]}}, lane_byte};
            out_data[j*16 +: 16] = lane_ext << shift_q;
        end
    end

endmodule

// File: tb/tb_int8_to_int16_expand.sv
// Self-checking bench for int8_to_int16_expand: directed and random traffic checked
// against a queue-based model of expected output beats.
module tb_int8_to_int16_expand;

    localparam int IN_LANES  = 4;
    localparam int OUT_LANES = 2;
    localparam int BEATS     = IN_LANES / OUT_LANES;

    typedef struct {
        logic [16*OUT_LANES-1:0] data;
        logic                    last;
    } beat_t;

    logic                    clk;
    logic                    rst_n;
    logic                    in_valid;
    logic                    in_ready;
    logic [8*IN_LANES-1:0]   in_data;
    logic [3:0]              in_shift;
    logic                    out_valid;
    logic                    out_ready;
    logic [16*OUT_LANES-1:0] out_data;
    logic                    out_last;

    beat_t q[$];
    int    n_compared;
    int    n_mismatched;
    int    n_accepted;

    int8_to_int16_expand #(.IN_LANES(IN_LANES), .OUT_LANES(OUT_LANES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shift  (in_shift),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected beats of one word, from plain integer arithmetic on the lanes.
    task automatic push_word(input logic [8*IN_LANES-1:0] w, input logic [3:0] s);
        int    se;
        int    v;
        beat_t b;
        logic [7:0]  byt;
        logic [31:0] bits;
        se = (int'(s) > 8) ? 8 : int'(s);
        for (int bi = 0; bi < BEATS; bi++) begin
            b.data = '0;
            for (int j = 0; j < OUT_LANES; j++) begin
                byt  = w[(bi*OUT_LANES + j)*8 +: 8];
                v    = int'($signed(byt)) * (1 << se);
                bits = v;
                b.data[j*16 +: 16] = bits[15:0];
            end
            b.last = (bi == BEATS - 1);
            q.push_back(b);
        end
    endtask

    // One cycle: check outputs mid-cycle against the model, then advance the model at the edge.
    task automatic step();
        logic exp_ready;
        logic do_in;
        logic do_out;
        @(negedge clk);
        exp_ready = (q.size() == 0) || (q.size() == 1 && out_ready);
        check("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
        check("out_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
        if (q.size() > 0) begin
            check("out_data", out_data, q[0].data);
            check("out_last", {31'b0, out_last}, {31'b0, q[0].last});
        end
        do_out = (q.size() > 0) && out_ready;
        do_in  = in_valid && exp_ready;
        @(posedge clk);
        if (do_out) void'(q.pop_front());
        if (do_in) begin
            push_word(in_data, in_shift);
            n_accepted++;
        end
        #1;
    endtask

    task automatic send(input logic [31:0] w, input logic [3:0] s);
        in_valid = 1'b1;
        in_data  = w;
        in_shift = s;
        step();
        in_valid = 1'b0;
        in_data  = $urandom;
        in_shift = 4'($urandom);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (q.size() > 0 && n < budget) begin
            step();
            n++;
        end
        check("drain_timeout", {31'b0, q.size() > 0}, 32'd0);
    endtask

    initial begin
        int cycles;
        n_compared   = 0;
        n_mismatched = 0;
        n_accepted   = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shift  = '0;
        out_ready = 1'b0;
        #12 rst_n = 1'b1;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_last", {31'b0, out_last}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        @(posedge clk);
        #1;

        $display("[TB] single word, shift 0");
        out_ready = 1'b1;
        send(32'h807F_FF01, 4'd0);
        check("t1_beat0", out_data, 32'hFFFF_0001);
        drain(10);

        $display("[TB] shift extremes and clamp");
        send(32'h807F_807F, 4'd8);
        check("t2_s8_beat0", out_data, 32'h8000_7F00);
        drain(10);
        send(32'h807F_807F, 4'd12);
        check("t2_s12_beat0", out_data, 32'h8000_7F00);
        drain(10);
        send(32'h0000_00FE, 4'd3);
        check("t2_s3_lane0", {16'b0, out_data[15:0]}, 32'h0000_FFF0);
        drain(10);

        $display("[TB] backpressure");
        out_ready = 1'b0;
        send(32'h1234_5678, 4'd2);
        for (int i = 0; i < 4; i++) step();
        out_ready = 1'b1;
        step();
        step();
        check("t3_empty", {31'b0, out_valid}, 32'd0);

        $display("[TB] streaming 8 words");
        in_valid = 1'b1;
        for (int w = 0; w < 8; w++) begin
            in_data  = $urandom;
            in_shift = 4'($urandom);
            step();
            if (w < 7) step();
        end
        in_valid = 1'b0;
        drain(10);

        $display("[TB] random valid/ready");
        n_accepted = 0;
        cycles     = 0;
        while (n_accepted < 1000 && cycles < 20000) begin
            in_valid  = $urandom_range(0, 1) == 1;
            in_data   = $urandom;
            in_shift  = 4'($urandom);
            out_ready = $urandom_range(0, 1) == 1;
            step();
            cycles++;
        end
        check("t5_words_accepted", n_accepted, 32'd1000);
        drain(100);

        $display("[TB] reset mid-word");
        send(32'hA5A5_5A5A, 4'd1);
        step();
        #2 rst_n = 1'b0;
        #1;
        check("t6_out_valid_async", {31'b0, out_valid}, 32'd0);
        check("t6_out_last_async", {31'b0, out_last}, 32'd0);
        check("t6_in_ready_async", {31'b0, in_ready}, 32'd1);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("t6_out_data_cleared", out_data, 32'd0);
        for (int i = 0; i < 3; i++) step();
        send(32'h0102_0304, 4'd0);
        drain(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
